// File: rtl/fixed_range_reduction_arbiter_if.sv
// Bus bundle for fixed_range_reduction_arbiter: NUM_REQ packed request lanes in,
// one normalised (Q1.(WIDTH-1)) result out.
interface fixed_range_reduction_arbiter_if #(
  parameter int WIDTH   = 16,
  parameter int NUM_REQ = 4
);
  localparam int MSB_WIDTH = $clog2(WIDTH);
  localparam int ID_WIDTH  = $clog2(NUM_REQ);

  // Handshake: a transfer happens on a rising clk edge when valid and ready are
  // both high. The sender holds its data stable while valid=1 and ready=0.
  // ready may depend on valid, but valid must never wait for ready.
  logic [NUM_REQ*WIDTH-1:0] data_in_0;
  logic [NUM_REQ-1:0]       data_in_0_valid;
  logic [NUM_REQ-1:0]       data_in_0_ready;
  logic [WIDTH-1:0]         data_out_0;
  logic [MSB_WIDTH-1:0]     msb_index_out;
  logic                     not_found_out;
  logic [ID_WIDTH-1:0]      req_id_out;
  logic                     data_out_0_valid;
  logic                     data_out_0_ready;

  modport master (
    output data_in_0, data_in_0_valid, data_out_0_ready,
    input  data_in_0_ready, data_out_0, msb_index_out, not_found_out,
           req_id_out, data_out_0_valid
  );

  modport slave (
    input  data_in_0, data_in_0_valid, data_out_0_ready,
    output data_in_0_ready, data_out_0, msb_index_out, not_found_out,
           req_id_out, data_out_0_valid
  );
endinterface

// File: rtl/fixed_range_reduction_arbiter.sv
// Round-robin arbiter sharing one leading-one detect + normalise datapath among NUM_REQ lanes.
// Define FIXED_RANGE_REDUCTION_ARB_PIPE_EN for a two-stage (latency 2) variant.
module fixed_range_reduction_arbiter #(
  parameter int WIDTH   = 16,
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  fixed_range_reduction_arbiter_if.slave bus,
  output logic [1:0]                 dbg_state_o,
  output logic [$clog2(NUM_REQ)-1:0] dbg_ptr_o
);
  localparam int MSB_WIDTH = $clog2(WIDTH);
  localparam int ID_WIDTH  = $clog2(NUM_REQ);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} stage_e;

  stage_e               out_state_q;
  logic [ID_WIDTH-1:0]  ptr_q, ptr_d;
  logic [WIDTH-1:0]     data_q;
  logic [MSB_WIDTH-1:0] msb_q;
  logic                 nf_q;
  logic [ID_WIDTH-1:0]  id_q;

  logic [WIDTH-1:0]     ops [NUM_REQ];
  logic                 grant_found;
  logic [ID_WIDTH-1:0]  grant_idx, cand;
  logic                 out_drain, can_accept, take, load_out;
  logic [NUM_REQ-1:0]   ready;
  logic [WIDTH-1:0]     dp_op, dp_norm;
  logic [ID_WIDTH-1:0]  dp_id;
  logic [MSB_WIDTH-1:0] dp_msb;
  logic                 dp_found;

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_unpack
    assign ops[r] = bus.data_in_0[r*WIDTH +: WIDTH];
  end

  assign out_drain = (out_state_q == FULL) && bus.data_out_0_ready;

  // First valid lane at or after the pointer, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = ptr_q;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_WIDTH'((int'(ptr_q) + k) % NUM_REQ);
      if (!grant_found && bus.data_in_0_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

`ifdef FIXED_RANGE_REDUCTION_ARB_PIPE_EN
  logic                s1_valid_q;
  logic [WIDTH-1:0]    s1_op_q;
  logic [ID_WIDTH-1:0] s1_id_q;

  // Stage 1 moves forward whenever the output stage is empty or draining.
  assign load_out    = s1_valid_q && ((out_state_q == EMPTY) || bus.data_out_0_ready);
  assign can_accept  = !s1_valid_q || load_out;
  assign dp_op       = s1_op_q;
  assign dp_id       = s1_id_q;
  assign dbg_state_o = {s1_valid_q, out_state_q == FULL};
`else
  assign can_accept  = (out_state_q == EMPTY) || bus.data_out_0_ready;
  assign load_out    = take;
  assign dp_op       = ops[grant_idx];
  assign dp_id       = grant_idx;
  assign dbg_state_o = {1'b0, out_state_q == FULL};
`endif

  assign take = !rst && grant_found && can_accept;

  always_comb begin
    ready = '0;
    if (take) ready[grant_idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (take) ptr_d = (grant_idx == ID_WIDTH'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
  end

  // Leading-one detect; zero operand leaves all outputs at their defaults.
  always_comb begin
    dp_found = 1'b0;
    dp_msb   = '0;
    dp_norm  = '0;
    for (int b = 0; b < WIDTH; b++) begin
      if (dp_op[b]) begin
        dp_found = 1'b1;
        dp_msb   = MSB_WIDTH'(b);
      end
    end
    if (dp_found) dp_norm = dp_op << (MSB_WIDTH'(WIDTH-1) - dp_msb);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_state_q <= EMPTY;
      ptr_q       <= '0;
      data_q      <= '0;
      msb_q       <= '0;
      nf_q        <= 1'b0;
      id_q        <= '0;
`ifdef FIXED_RANGE_REDUCTION_ARB_PIPE_EN
      s1_valid_q  <= 1'b0;
      s1_op_q     <= '0;
      s1_id_q     <= '0;
`endif
    end else begin
      ptr_q <= ptr_d;
`ifdef FIXED_RANGE_REDUCTION_ARB_PIPE_EN
      if (take) begin
        s1_valid_q <= 1'b1;
        s1_op_q    <= ops[grant_idx];
        s1_id_q    <= grant_idx;
      end else if (load_out) begin
        s1_valid_q <= 1'b0;
      end
`endif
      if (load_out) begin
        out_state_q <= FULL;
        data_q      <= dp_norm;
        msb_q       <= dp_msb;
        nf_q        <= !dp_found;
        id_q        <= dp_id;
      end else if (out_drain) begin
        out_state_q <= EMPTY;
      end
    end
  end

  assign bus.data_in_0_ready  = ready;
  assign bus.data_out_0       = data_q;
  assign bus.msb_index_out    = msb_q;
  assign bus.not_found_out    = nf_q;
  assign bus.req_id_out       = id_q;
  assign bus.data_out_0_valid = (out_state_q == FULL);
  assign dbg_ptr_o            = ptr_q;
endmodule

// File: tb/tb_fixed_range_reduction_arbiter.sv
// Bench for fixed_range_reduction_arbiter: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_fixed_range_reduction_arbiter;
  localparam int WIDTH     = 16;
  localparam int NUM_REQ   = 4;
  localparam int MSB_WIDTH = 4;
  localparam int ID_WIDTH  = 2;
  localparam int EW        = ID_WIDTH + 1 + MSB_WIDTH + WIDTH;
`ifdef FIXED_RANGE_REDUCTION_ARB_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fixed_range_reduction_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();
  logic [1:0]          dbg_state;
  logic [ID_WIDTH-1:0] dbg_ptr;

  fixed_range_reduction_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state),
    .dbg_ptr_o   (dbg_ptr)
  );

  // scoreboard / model state
  int checks   = 0;
  int failures = 0;
  logic [EW-1:0]      exp_q[$];
  int                 m_ptr;
  int                 waits [NUM_REQ];
  logic [WIDTH-1:0]   cur_d [NUM_REQ];
  logic [NUM_REQ-1:0] cur_v, last_hs, last_rdy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: msb by repeated shifting, normalise by plain shift-and-mask.
  function automatic logic [EW-1:0] model_res(input int id, input logic [WIDTH-1:0] x);
    int unsigned v;
    int          msb;
    int unsigned n;
    v = x;
    if (v == 0) return {ID_WIDTH'(id), 1'b1, MSB_WIDTH'(0), WIDTH'(0)};
    msb = 0;
    while ((v >> (msb + 1)) != 0) msb++;
    n = (v << (WIDTH - 1 - msb)) & ((1 << WIDTH) - 1);
    return {ID_WIDTH'(id), 1'b0, MSB_WIDTH'(msb), WIDTH'(n)};
  endfunction

  task automatic chk_outputs();
    logic [EW-1:0] head;
    if (exp_q.size() == 0) begin
      chk("out_valid_idle", bus.data_out_0_valid, 0);
    end else begin
`ifndef FIXED_RANGE_REDUCTION_ARB_PIPE_EN
      chk("out_valid", bus.data_out_0_valid, 1);
`endif
      if (bus.data_out_0_valid) begin
        head = exp_q[0];
        chk("out_id",   bus.req_id_out,    head[EW-1 -: ID_WIDTH]);
        chk("out_nf",   bus.not_found_out, head[WIDTH+MSB_WIDTH]);
        chk("out_msb",  bus.msb_index_out, head[WIDTH +: MSB_WIDTH]);
        chk("out_data", bus.data_out_0,    head[WIDTH-1:0]);
      end
    end
  endtask

  // driver: one clock cycle, entered and left at a falling edge
  task automatic step(input logic [NUM_REQ-1:0] v, input logic ordy);
    int g;
    logic [NUM_REQ-1:0] exp_rdy;
    chk_outputs();
    chk("ptr", dbg_ptr, m_ptr);
    bus.data_in_0_valid  = v;
    bus.data_out_0_ready = ordy;
    for (int r = 0; r < NUM_REQ; r++) bus.data_in_0[r*WIDTH +: WIDTH] = cur_d[r];
    #1;
    g = -1;
    for (int k = 0; k < NUM_REQ; k++)
      if (g < 0 && v[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
    exp_rdy = '0;
    if (g >= 0 && (exp_q.size() < LAT || ordy)) exp_rdy[g] = 1'b1;
    last_rdy = bus.data_in_0_ready;
    chk("ready", bus.data_in_0_ready, exp_rdy);
    if (bus.data_out_0_valid && ordy && exp_q.size() > 0) void'(exp_q.pop_front());
    last_hs = exp_rdy;
    for (int r = 0; r < NUM_REQ; r++) if (!v[r]) waits[r] = 0;
    if (exp_rdy != '0) begin
      exp_q.push_back(model_res(g, cur_d[g]));
      for (int r = 0; r < NUM_REQ; r++) if (r != g && v[r]) waits[r]++;
      chk("no_starve", waits[g] < NUM_REQ, 1);
      waits[g] = 0;
      m_ptr = (g + 1) % NUM_REQ;
    end
    @(negedge clk);
  endtask

  task automatic apply_reset(input logic [NUM_REQ-1:0] v);
    rst = 1'b1;
    bus.data_in_0_valid  = v;
    bus.data_out_0_ready = 1'b1;
    for (int r = 0; r < NUM_REQ; r++) bus.data_in_0[r*WIDTH +: WIDTH] = cur_d[r];
    #1;
    chk("rst_ready", bus.data_in_0_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_ptr = 0;
    for (int r = 0; r < NUM_REQ; r++) waits[r] = 0;
    chk("rst_valid", bus.data_out_0_valid, 0);
    chk("rst_data",  bus.data_out_0, 0);
    chk("rst_msb",   bus.msb_index_out, 0);
    chk("rst_nf",    bus.not_found_out, 0);
    chk("rst_id",    bus.req_id_out, 0);
    chk("rst_ptr",   dbg_ptr, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < NUM_REQ; r++) cur_d[r] = '0;
    cur_v = '0;
    last_hs = '0;
    last_rdy = '0;
    bus.data_in_0 = '0;
    bus.data_in_0_valid = '0;
    bus.data_out_0_ready = 1'b0;
    apply_reset('0);

    // single request from r2
    cur_d[2] = 16'h0010;
    step(4'b0100, 1'b1);
    for (int i = 1; i <= LAT; i++) begin
      chk("t1_lat_valid", bus.data_out_0_valid, i == LAT);
      if (i == LAT) begin
        chk("t1_data", bus.data_out_0, 16'h8000);
        chk("t1_msb",  bus.msb_index_out, 4);
        chk("t1_nf",   bus.not_found_out, 0);
        chk("t1_id",   bus.req_id_out, 2);
      end
      step('0, 1'b1);
    end
    chk("t1_one_cycle", bus.data_out_0_valid, 0);
    chk("t1_hold_data", bus.data_out_0, 16'h8000);

    // round robin, all four valid from pointer 0
    apply_reset('0);
    cur_d[0] = 16'h0003; cur_d[1] = 16'h00A0; cur_d[2] = 16'h0001; cur_d[3] = 16'h8000;
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b1);
      chk("rr_grant", last_rdy, 4'b0001 << (i % NUM_REQ));
    end
    for (int i = 0; i < 3; i++) step('0, 1'b1);

    // zero operand on r1
    cur_d[1] = 16'h0000;
    step(4'b0010, 1'b1);
    for (int i = 0; i < LAT - 1; i++) step('0, 1'b0);
    chk("zero_valid", bus.data_out_0_valid, 1);
    chk("zero_nf",    bus.not_found_out, 1);
    chk("zero_data",  bus.data_out_0, 0);
    chk("zero_msb",   bus.msb_index_out, 0);
    chk("zero_id",    bus.req_id_out, 1);
    step('0, 1'b1);
    for (int i = 0; i < 2; i++) step('0, 1'b1);

    // back-pressure for 3 cycles, then drain and accept together
    cur_d[0] = 16'h1234; cur_d[3] = 16'h0F00;
    step(4'b0001, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b1001, 1'b0);
    step(4'b1001, 1'b1);
    for (int i = 0; i < 3; i++) step('0, 1'b1);

    // reset with a result in flight and r2 pending
    cur_d[1] = 16'h0005; cur_d[2] = 16'h0040;
    step(4'b0010, 1'b0);
    apply_reset(4'b0100);
    step(4'b1100, 1'b1);
    chk("post_rst_grant", last_rdy, 4'b0100);
    for (int i = 0; i < 3; i++) step('0, 1'b1);

    // random traffic
    cur_v = '0;
    last_hs = '0;
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (!cur_v[r] || last_hs[r]) begin
          cur_v[r] = ($urandom_range(0, 99) < 60);
          case ($urandom_range(0, 7))
            0:       cur_d[r] = '0;
            1:       cur_d[r] = 16'h8000 >> $urandom_range(0, 15);
            default: cur_d[r] = WIDTH'($urandom);
          endcase
        end
      end
      step(cur_v, $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 6; i++) step('0, 1'b1);
    chk("drain_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
